// File: rtl/lcd_sequencer.sv
// HD44780 host-side sequencer: power-up wait, 8-bit init, then character/clear
// writes with automatic DDRAM addressing for a 16x2 panel.
module lcd_sequencer #(
  parameter int unsigned T_PWRUP = 750000,
  parameter int unsigned T_CMD   = 2000,
  parameter int unsigned T_CLR   = 82000,
  parameter int unsigned CNT_W   = 20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_valid,
  input  logic [7:0] wr_char,
  output logic       wr_ready,
  input  logic       clr_req,
  output logic       init_done,
  output logic       lcd_start,
  output logic       lcd_rs,
  output logic [7:0] lcd_data,
  input  logic       lcd_done
);

  typedef enum logic [2:0] {PWRUP, ISSUE, WAIT_DONE, DELAY, IDLE} state_t;
  // What the byte currently on the bus is, which decides what follows its delay
  typedef enum logic [1:0] {K_INIT, K_ADDR, K_CHAR, K_CLR} kind_t;

  localparam logic [CNT_W-1:0] CNT_PWRUP = CNT_W'(T_PWRUP - 1);
  localparam logic [CNT_W-1:0] CNT_CMD   = CNT_W'(T_CMD - 1);
  localparam logic [CNT_W-1:0] CNT_CLR   = CNT_W'(T_CLR - 1);

  state_t           state, state_n;
  kind_t            kind, kind_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       init_idx, init_idx_n;
  logic [7:0]       char_q, char_q_n;
  logic             row, row_n;
  logic [3:0]       col, col_n;
  logic             rs_n;
  logic [7:0]       data_n;
  logic             init_done_n;

  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    init_byte = 8'h38;
      2'd1:    init_byte = 8'h0C;
      2'd2:    init_byte = 8'h06;
      default: init_byte = 8'h01;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= PWRUP;
      kind      <= K_INIT;
      cnt       <= CNT_PWRUP;
      init_idx  <= '0;
      char_q    <= '0;
      row       <= 1'b0;
      col       <= '0;
      lcd_rs    <= 1'b0;
      lcd_data  <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_n;
      kind      <= kind_n;
      cnt       <= cnt_n;
      init_idx  <= init_idx_n;
      char_q    <= char_q_n;
      row       <= row_n;
      col       <= col_n;
      lcd_rs    <= rs_n;
      lcd_data  <= data_n;
      init_done <= init_done_n;
    end
  end

  always_comb begin
    state_n     = state;
    kind_n      = kind;
    cnt_n       = cnt;
    init_idx_n  = init_idx;
    char_q_n    = char_q;
    row_n       = row;
    col_n       = col;
    rs_n        = lcd_rs;
    data_n      = lcd_data;
    init_done_n = init_done;

    case (state)
      PWRUP: begin
        if (cnt == '0) begin
          state_n    = ISSUE;
          kind_n     = K_INIT;
          init_idx_n = '0;
          rs_n       = 1'b0;
          data_n     = init_byte(2'd0);
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end

      ISSUE: state_n = WAIT_DONE;

      WAIT_DONE: begin
        if (lcd_done) begin
          state_n = DELAY;
          // A data byte of 0x01 is a character, so only a command 0x01 gets the long wait
          cnt_n   = (!lcd_rs && lcd_data == 8'h01) ? CNT_CLR : CNT_CMD;
          if (kind == K_CHAR) begin
            if (col == 4'd15) begin
              col_n = '0;
              row_n = ~row;
            end else begin
              col_n = col + 4'd1;
            end
          end else if (kind == K_CLR) begin
            row_n = 1'b0;
            col_n = '0;
          end
        end
      end

      DELAY: begin
        if (cnt == '0) begin
          case (kind)
            K_INIT: begin
              if (init_idx == 2'd3) begin
                state_n     = IDLE;
                init_done_n = 1'b1;
                row_n       = 1'b0;
                col_n       = '0;
              end else begin
                state_n    = ISSUE;
                init_idx_n = init_idx + 2'd1;
                rs_n       = 1'b0;
                data_n     = init_byte(init_idx + 2'd1);
              end
            end
            K_ADDR: begin
              state_n = ISSUE;
              kind_n  = K_CHAR;
              rs_n    = 1'b1;
              data_n  = char_q;
            end
            default: state_n = IDLE;
          endcase
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end

      IDLE: begin
        if (init_done) begin
          if (clr_req) begin
            state_n = ISSUE;
            kind_n  = K_CLR;
            rs_n    = 1'b0;
            data_n  = 8'h01;
          end else if (wr_valid) begin
            state_n  = ISSUE;
            char_q_n = wr_char;
            if (col == '0) begin
              kind_n = K_ADDR;
              rs_n   = 1'b0;
              data_n = row ? 8'hC0 : 8'h80;
            end else begin
              kind_n = K_CHAR;
              rs_n   = 1'b1;
              data_n = wr_char;
            end
          end
        end
      end

      default: state_n = PWRUP;
    endcase
  end

  assign lcd_start = (state == ISSUE);
  assign wr_ready  = (state == IDLE) && init_done;

endmodule

// File: tb/tb_lcd_sequencer.sv
// Directed bench for lcd_sequencer with a behavioural byte-controller model.
module tb_lcd_sequencer;

  localparam int unsigned T_PWRUP = 20;
  localparam int unsigned T_CMD   = 5;
  localparam int unsigned T_CLR   = 10;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_char = '0;
  logic       clr_req = 1'b0;
  logic       wr_ready, init_done, lcd_start, lcd_rs, lcd_done;
  logic [7:0] lcd_data;
  logic       model_done, spur_done = 1'b0;

  assign lcd_done = model_done | spur_done;

  always #5 clk = ~clk;

  lcd_sequencer #(
    .T_PWRUP(T_PWRUP),
    .T_CMD  (T_CMD),
    .T_CLR  (T_CLR),
    .CNT_W  (20)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_valid (wr_valid),
    .wr_char  (wr_char),
    .wr_ready (wr_ready),
    .clr_req  (clr_req),
    .init_done(init_done),
    .lcd_start(lcd_start),
    .lcd_rs   (lcd_rs),
    .lcd_data (lcd_data),
    .lcd_done (lcd_done)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Byte controller: done pulse a fixed time after each start
  logic busy;
  int   bcnt;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy       <= 1'b0;
      bcnt       <= 0;
      model_done <= 1'b0;
    end else begin
      model_done <= 1'b0;
      if (busy) begin
        if (bcnt == 1) begin
          model_done <= 1'b1;
          busy       <= 1'b0;
        end
        bcnt <= bcnt - 1;
      end
      if (lcd_start) begin
        busy <= 1'b1;
        bcnt <= 15;
      end
    end
  end

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         gap;
    bit         stable;
    int         scyc;
  } wr_t;

  wr_t q[$];
  wr_t cur;
  bit  active = 1'b0;
  int  last_done = 0;
  int  overlap = 0;
  int  ready_bad = 0;

  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      active = 1'b0;
    end else begin
      if (active && wr_ready) ready_bad++;
      if (lcd_start) begin
        if (active) overlap++;
        active     = 1'b1;
        cur.rs     = lcd_rs;
        cur.data   = lcd_data;
        cur.gap    = cyc - last_done;
        cur.stable = 1'b1;
        cur.scyc   = cyc;
      end else if (active) begin
        if (lcd_rs != cur.rs || lcd_data != cur.data) cur.stable = 1'b0;
        if (lcd_done) begin
          q.push_back(cur);
          active    = 1'b0;
          last_done = cyc;
        end
      end
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", nm, act, act, exp, exp);
    end
  endtask

  task automatic wait_ready(output int rg);
    bit got = 1'b0;
    for (int k = 0; k < 600 && !got; k++) begin
      @(negedge clk);
      if (wr_ready) got = 1'b1;
    end
    if (!got) begin
      chk("ready_timeout", 0, 1);
      rg = -1;
    end else begin
      rg = cyc - last_done;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_start"}, lcd_start, 0);
    chk({tag, "_rs"}, lcd_rs, 0);
    chk({tag, "_data"}, lcd_data, 0);
    chk({tag, "_ready"}, wr_ready, 0);
    chk({tag, "_init_done"}, init_done, 0);
  endtask

  task automatic run_init();
    logic [7:0] ib[4];
    int         ig[4];
    int         rg;
    wr_t        e;
    ib = '{8'h38, 8'h0C, 8'h06, 8'h01};
    ig = '{T_PWRUP, T_CMD + 1, T_CMD + 1, T_CMD + 1};
    @(negedge clk);
    reset_n   = 1'b1;
    last_done = cyc;
    wait_ready(rg);
    chk("init_clr_gap", rg, T_CLR + 1);
    chk("init_count", q.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (q.size() > 0) begin
        e = q.pop_front();
        chk($sformatf("init%0d_data", k), e.data, ib[k]);
        chk($sformatf("init%0d_rs", k), e.rs, 0);
        chk($sformatf("init%0d_gap", k), e.gap, ig[k]);
        chk($sformatf("init%0d_stable", k), e.stable, 1);
      end else begin
        chk($sformatf("init%0d_missing", k), 0, 1);
      end
    end
    chk("init_done_set", init_done, 1);
    chk("init_ready", wr_ready, 1);
  endtask

  typedef struct {
    bit         clr;
    bit         valid;
    logic [7:0] ch;
    bit         has_addr;
    logic [7:0] addr;
    logic [7:0] data;
    bit         rs;
    int         rgap;
  } vec_t;

  // Caller must be at a negedge with wr_ready high.
  task automatic apply(input vec_t v, input string nm);
    int  dcyc, rg, n;
    wr_t e;
    clr_req  = v.clr;
    wr_valid = v.valid;
    wr_char  = v.ch;
    dcyc     = cyc;
    @(negedge clk);
    clr_req  = 1'b0;
    wr_valid = 1'b0;
    chk({nm, "_ready_low"}, wr_ready, 0);
    wait_ready(rg);
    n = v.has_addr ? 2 : 1;
    chk({nm, "_nbytes"}, q.size(), n);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({nm, "_latency"}, e.scyc - dcyc, 1);
      chk({nm, "_b0_data"}, e.data, v.has_addr ? v.addr : v.data);
      chk({nm, "_b0_rs"}, e.rs, v.has_addr ? 0 : v.rs);
      chk({nm, "_b0_stable"}, e.stable, 1);
    end
    if (v.has_addr && q.size() > 0) begin
      e = q.pop_front();
      chk({nm, "_b1_data"}, e.data, v.data);
      chk({nm, "_b1_rs"}, e.rs, v.rs);
      chk({nm, "_b1_gap"}, e.gap, T_CMD + 1);
      chk({nm, "_b1_stable"}, e.stable, 1);
    end
    chk({nm, "_ready_gap"}, rg, v.rgap);
    q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

  vec_t tv[$];
  vec_t v;
  bit   found;

  initial begin
    // 33 characters across both rows and back; index 16 is 'Z' opening row 1
    for (int i = 0; i < 33; i++) begin
      v.clr      = 1'b0;
      v.valid    = 1'b1;
      v.ch       = (i == 16) ? 8'h5A : 8'(8'h41 + i);
      v.has_addr = (i % 16 == 0);
      v.addr     = ((i / 16) % 2 == 1) ? 8'hC0 : 8'h80;
      v.data     = v.ch;
      v.rs       = 1'b1;
      v.rgap     = T_CMD + 1;
      tv.push_back(v);
    end
    tv.push_back('{1'b1, 1'b1, 8'h51, 1'b0, 8'h00, 8'h01, 1'b0, T_CLR + 1});
    tv.push_back('{1'b0, 1'b1, 8'h51, 1'b1, 8'h80, 8'h51, 1'b1, T_CMD + 1});
    tv.push_back('{1'b0, 1'b1, 8'h01, 1'b0, 8'h00, 8'h01, 1'b1, T_CMD + 1});

    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    run_init();

    for (int i = 0; i < tv.size(); i++) apply(tv[i], $sformatf("v%0d", i));

    // Spurious done while idle
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    repeat (20) @(negedge clk);
    chk("spur_no_start", q.size() + int'(active), 0);
    chk("spur_ready", wr_ready, 1);
    apply('{1'b0, 1'b1, 8'h52, 1'b0, 8'h00, 8'h52, 1'b1, T_CMD + 1}, "after_spur");

    // Reset while waiting for the second init byte's done
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n   = 1'b1;
    last_done = cyc;
    found     = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (lcd_start && lcd_data == 8'h0C) found = 1'b1;
    end
    chk("midreset_found", found, 1);
    repeat (3) @(negedge clk);
    chk("midreset_pre_data", lcd_data, 8'h0C);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("midreset");
    @(negedge clk);
    q.delete();
    repeat (3) @(negedge clk);
    run_init();
    apply('{1'b0, 1'b1, 8'h41, 1'b1, 8'h80, 8'h41, 1'b1, T_CMD + 1}, "post_reset");

    chk("start_overlap", overlap, 0);
    chk("ready_during_busy", ready_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
